// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: upstream instruction handshake, register-file
// ports, writeback request and downstream operand handshake.
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [ADDR_W-1:0] rf_addr_a;
  logic [ADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [ADDR_W-1:0] rf_addr_c;
  logic [DATA_W-1:0] rf_data_c;
  logic              rf_wr_c;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_opa;
  logic [DATA_W-1:0] out_opb;
  logic [ADDR_W-1:0] out_dest;
  logic              wb_err;

  modport master (
    input  in_valid, in_instr,
    input  rf_data_a, rf_data_b,
    input  wb_valid, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output rf_addr_a, rf_addr_b,
    output rf_addr_c, rf_data_c, rf_wr_c,
    output out_valid, out_instr,
    output out_opa, out_opb, out_dest,
    output wb_err
  );

  modport slave (
    output in_valid, in_instr,
    output rf_data_a, rf_data_b,
    output wb_valid, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  rf_addr_a, rf_addr_b,
    input  rf_addr_c, rf_data_c, rf_wr_c,
    input  out_valid, out_instr,
    input  out_opa, out_opb, out_dest,
    input  wb_err
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage in front of a 3-port register file, with a
// pending-write scoreboard that stalls RAW/WAW hazards until writeback.
module operand_fetch #(
  parameter int RF_WAIT = 1,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input logic             Clk,
  input logic             Reset,
  operand_fetch_if.master bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = (RF_WAIT < 2) ? 1 : $clog2(RF_WAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RF_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    READ,
    VALID
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] data_c_q, data_c_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              wr_c_q, wr_c_d;
  logic              err_q, err_d;

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs, rt, rd, dest;
  logic              writes, uses_rt, hazard;

  assign op = instr_q[31:26];
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign rd = instr_q[15:11];

  assign writes  = !(op inside {6'h2B, 6'h04, 6'h05, 6'h02});
  assign uses_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
  assign dest    = !writes ? '0 : (op == 6'h00) ? rd : rt;

  assign hazard = pend_q[rs]
                | (uses_rt & pend_q[rt])
                | ((dest != '0) & pend_q[dest]);

  assign bus.in_ready  = in_ready_q;
  assign bus.rf_addr_a = rs;
  assign bus.rf_addr_b = rt;
  assign bus.rf_addr_c = addr_c_q;
  assign bus.rf_data_c = data_c_q;
  assign bus.rf_wr_c   = wr_c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_opa   = opa_q;
  assign bus.out_opb   = opb_q;
  assign bus.out_dest  = dest;
  assign bus.wb_err    = err_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    addr_c_d    = addr_c_q;
    data_c_d    = data_c_q;
    wr_c_d      = bus.wb_valid;
    err_d       = err_q;
    pend_d      = pend_q;

    // Clear lands with the RF write; a same-edge set overrides it below
    if (wr_c_q) pend_d[addr_c_q] = 1'b0;

    if (bus.wb_valid) begin
      addr_c_d = bus.wb_addr;
      data_c_d = bus.wb_data;
      if (bus.wb_addr != '0 && !pend_q[bus.wb_addr]) err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          instr_d    = bus.in_instr;
          in_ready_d = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (!hazard) begin
          cnt_d   = CNT_LOAD;
          state_d = READ;
        end
      end
      READ: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          opa_d       = (rs == '0) ? '0 : bus.rf_data_a;
          opb_d       = (rt == '0) ? '0 : bus.rf_data_b;
          out_valid_d = 1'b1;
          state_d     = VALID;
        end
      end
      VALID: begin
        if (bus.out_ready) begin
          if (dest != '0) pend_d[dest] = 1'b1;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      addr_c_q    <= '0;
      data_c_q    <= '0;
      wr_c_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      addr_c_q    <= addr_c_d;
      data_c_q    <= data_c_d;
      wr_c_q      <= wr_c_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random instruction mix,
// checked against a register/scoreboard reference model.
module tb_operand_fetch;
  localparam int RF_WAIT = 1;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  operand_fetch_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  operand_fetch #(
    .RF_WAIT(RF_WAIT),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.master)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'hFFFF_FFFF;
    if (i == 1) return 32'd5;
    if (i == 2) return 32'd7;
    return 32'h0000_0100 + 32'(i);
  endfunction

  // Register file: reloads while Reset is low, clocked write port C
  logic [31:0] rf [32];
  always @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (bus.rf_wr_c && bus.rf_addr_c != 5'd0) begin
      rf[bus.rf_addr_c] <= bus.rf_data_c;
    end
  end
  assign bus.rf_data_a = rf[bus.rf_addr_a];
  assign bus.rf_data_b = rf[bus.rf_addr_b];

  bit          pend_m [32];
  logic [31:0] reg_m  [32];
  bit          err_m;
  int          n_chk;
  int          n_fail;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      pend_m[i] = 1'b0;
      reg_m[i]  = init_val(i);
    end
    err_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs,
                                     logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'h5A5};
  endfunction

  function automatic bit f_uses_rt(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05;
  endfunction

  function automatic logic [4:0] f_dest(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02) return 5'd0;
    return (op == 6'h00) ? ins[15:11] : ins[20:16];
  endfunction

  function automatic bit f_conflict(logic [31:0] ins, int r);
    logic [4:0] d;
    d = f_dest(ins);
    return (32'(ins[25:21]) == r) || (f_uses_rt(ins) && 32'(ins[20:16]) == r)
        || (d != 5'd0 && 32'(d) == r);
  endfunction

  function automatic bit f_hazard(logic [31:0] ins);
    bit h;
    h = 1'b0;
    for (int r = 1; r < 32; r++) if (pend_m[r] && f_conflict(ins, r)) h = 1'b1;
    return h;
  endfunction

  task automatic chk_pend(string tag);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) e[i] = pend_m[i];
    chk(tag, dut.pend_q, e);
  endtask

  task automatic send(logic [31:0] ins);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    tick();
    bus.in_valid = 1'b0;
    bus.in_instr = $urandom;
    chk("in_ready_after_accept", bus.in_ready, 1'b0);
  endtask

  task automatic await_valid(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 100) begin
      tick();
      edges++;
    end
    chk("out_valid_reached", bus.out_valid, 1'b1);
  endtask

  task automatic chk_bundle(string tag, logic [31:0] ins);
    logic [31:0] ea, eb;
    ea = (ins[25:21] == 5'd0) ? 32'd0 : reg_m[ins[25:21]];
    eb = (ins[20:16] == 5'd0) ? 32'd0 : reg_m[ins[20:16]];
    chk({tag, "_instr"}, bus.out_instr, ins);
    chk({tag, "_opa"}, bus.out_opa, ea);
    chk({tag, "_opb"}, bus.out_opb, eb);
    chk({tag, "_dest"}, 32'(bus.out_dest), 32'(f_dest(ins)));
  endtask

  task automatic handshake(logic [31:0] ins);
    logic [4:0] d;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    d = f_dest(ins);
    if (d != 5'd0) pend_m[d] = 1'b1;
    chk("out_valid_after_hs", bus.out_valid, 1'b0);
    chk("in_ready_after_hs", bus.in_ready, 1'b1);
  endtask

  task automatic wb(logic [4:0] a, logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    if (a != 5'd0 && !pend_m[a]) err_m = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_wr_c_pulse", bus.rf_wr_c, 1'b1);
    chk("wb_addr_c", 32'(bus.rf_addr_c), 32'(a));
    chk("wb_data_c", bus.rf_data_c, d);
    if (a != 5'd0) reg_m[a] = d;
    tick();
    pend_m[a] = 1'b0;
    chk("wb_wr_c_drop", bus.rf_wr_c, 1'b0);
    chk("wb_err", bus.wb_err, err_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] ins;
  logic [5:0]  opsel [8];
  int          lat;
  int          a;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    opsel  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05, 6'h0D};
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_wr_c", bus.rf_wr_c, 1'b0);
    chk("rst_wb_err", bus.wb_err, 1'b0);
    chk("rst_out_opa", bus.out_opa, 32'd0);
    chk_pend("rst_pend");
    Reset = 1'b1;

    // r3 = r1 op r2
    ins = mk(6'h00, 5'd1, 5'd2, 5'd3);
    send(ins);
    await_valid(lat);
    chk("latency_nohazard", 32'(lat), 32'(2 + RF_WAIT));
    chk_bundle("add", ins);
    handshake(ins);
    chk_pend("pend_r3_set");

    // RAW on r3 stalls until the writeback lands
    ins = mk(6'h00, 5'd3, 5'd0, 5'd5);
    send(ins);
    repeat (3) tick();
    chk("raw_stall", bus.out_valid, 1'b0);
    wb(5'd3, 32'd12);
    await_valid(lat);
    chk_bundle("raw", ins);
    chk("raw_opa_12", bus.out_opa, 32'd12);
    handshake(ins);
    chk_pend("pend_r5_set");

    // r0 reads as zero; lw to r0 marks nothing
    ins = mk(6'h23, 5'd0, 5'd0, 5'd7);
    send(ins);
    await_valid(lat);
    chk_bundle("lw_r0", ins);
    handshake(ins);
    chk_pend("pend_after_lw_r0");

    wb(5'd9, 32'hABCD_0009);
    repeat (3) tick();
    chk("wb_err_sticky", bus.wb_err, 1'b1);
    wb(5'd5, 32'h0000_0555);
    wb(5'd0, 32'h1234_5678);
    chk_pend("pend_after_wbs");

    // Held VALID, then set and clear of r4 on the same edge
    ins = mk(6'h08, 5'd1, 5'd4, 5'd0);
    send(ins);
    await_valid(lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_in_ready", bus.in_ready, 1'b0);
      chk_bundle("hold", ins);
    end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd4;
    bus.wb_data  = 32'h0000_0044;
    err_m = 1'b1;
    tick();
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b1;
    reg_m[4] = 32'h0000_0044;
    chk("same_edge_wr_c", bus.rf_wr_c, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    pend_m[4] = 1'b1;
    chk_pend("set_wins");
    wb(5'd4, 32'h0000_0444);
    chk_pend("pend_r4_cleared");

    // Asynchronous reset with a bundle and a write in flight
    ins = mk(6'h00, 5'd1, 5'd2, 5'd6);
    send(ins);
    await_valid(lat);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd7;
    bus.wb_data  = 32'h7777_7777;
    tick();
    bus.wb_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    chk("pre_rst_wr_c", bus.rf_wr_c, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_wr_c", bus.rf_wr_c, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_wb_err", bus.wb_err, 1'b0);
    chk_pend("arst_pend");
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    chk_pend("post_rst_pend");

    for (int k = 0; k < 40; k++) begin
      ins = mk(opsel[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 7);
        wb(5'(a), $urandom);
      end
      send(ins);
      if (f_hazard(ins)) begin
        repeat (2) tick();
        chk("rand_stall", bus.out_valid, 1'b0);
        for (int r = 1; r < 8; r++) begin
          if (pend_m[r] && f_conflict(ins, r)) wb(5'(r), $urandom);
        end
        await_valid(lat);
      end else begin
        await_valid(lat);
        chk("rand_latency", 32'(lat), 32'(2 + RF_WAIT));
      end
      chk_bundle("rand", ins);
      repeat ($urandom_range(0, 2)) tick();
      chk_bundle("rand_held", ins);
      handshake(ins);
      chk_pend("rand_pend");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the 32x32 register file (3-port: two async-read ports A/B, one clocked write port C).
- Accepts one instruction at a time over a valid/ready handshake and drives the register file's read addresses from it.
- Waits out the register-file read delay, then presents both operands downstream over a second valid/ready handshake.
- Owns the register file's write port: registers writeback requests onto AddrC/DataC/WrC, and keeps a pending-write scoreboard that stalls RAW/WAW hazards.

Parameters:
RF_WAIT, 1, number of full Clk cycles that read addresses are held stable before operands are sampled (>=1; covers the 4 ns RF read delay)
DATA_W, 32, operand/instruction width
ADDR_W, 5, register address width (32 registers)

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (Reset=0 resets)
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept an instruction
in_instr  input  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd
rf_addr_a  output  5  to RF AddrA (= rs of held instruction)
rf_addr_b  output  5  to RF AddrB (= rt of held instruction)
rf_data_a  input  32  from RF DataA
rf_data_b  input  32  from RF DataB
rf_addr_c  output  5  to RF AddrC
rf_data_c  output  32  to RF DataC
rf_wr_c  output  1  to RF WrC
wb_valid  input  1  writeback request (always accepted)
wb_addr  input  5  writeback destination
wb_data  input  32  writeback value
out_valid  output  1  operand bundle valid
out_ready  input  1  downstream accepts bundle
out_instr  output  32  held instruction
out_opa  output  32  operand A (rs value)
out_opb  output  32  operand B (rt value)
out_dest  output  5  destination register (0 if the instruction does not write)
wb_err  output  1  sticky: a writeback targeted a non-pending register

Behaviour:
- Reset=0 (async, any state): FSM to IDLE; instr/out_* regs 0; scoreboard 0; rf_wr_c, rf_addr_c, rf_data_c 0; wb_err 0; in_ready then =1.
- Decode:
  - writes = opcode not in {0x2B, 0x04, 0x05, 0x02}.
  - dest = rd if opcode==0, else rt; forced to 0 when !writes.
  - uses_rt = opcode in {0x00, 0x2B, 0x04, 0x05}; rs is always used.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_instr -> CHECK.
  - CHECK: hazard = pend[rs] | (uses_rt & pend[rt]) | (dest!=0 & pend[dest]). On hazard, remain in CHECK (stall). Otherwise load counter=RF_WAIT -> READ.
  - READ: decrement counter. At the edge ending the last READ cycle, capture out_opa=rf_data_a and out_opb=rf_data_b, forcing 0 when the address is 0 -> VALID.
  - VALID: out_valid=1 and outputs held stable until out_ready. On handshake: set pend[dest] if dest!=0 -> IDLE.
- rf_addr_a/b are driven continuously from the latched instruction and are stable through CHECK/READ.
- Latency: no hazard, accept at edge E -> out_valid first high in cycle E+2+RF_WAIT. Throughput: 1 instruction per 3+RF_WAIT cycles.
- Writeback:
  - wb_valid at edge E registers rf_addr_c=wb_addr, rf_data_c=wb_data, rf_wr_c=1 for exactly one cycle after E.
  - pend[wb_addr] clears at edge E+1.
  - Back-to-back writebacks give back-to-back rf_wr_c pulses.
- pend[0] is never set. A writeback to addr 0 is passed through and causes no error.
- wb_valid to a non-pending address (addr!=0): write is still passed through; wb_err set and held until Reset.
- Simultaneous set (VALID handshake) and clear (wb) of the same bit on one edge: set wins.
- A CHECK stall resolves in the cycle after the pend bit clears; operands are then re-read via READ, so no forwarding is needed.
- Reset mid-READ/VALID: the bundle is discarded, the scoreboard is lost, and no rf_wr_c is issued.

Test Plan:
- Reset=0 pulse mid-VALID with out_ready=0 -> out_valid, rf_wr_c, in_ready-low all drop asynchronously; after release in_ready=1, scoreboard 0.
- RF preloaded r1=5, r2=7; issue opcode 0 rs=1 rt=2 rd=3, out_ready=1, RF_WAIT=1 -> out_valid 3 cycles after accept, opa=5, opb=7, dest=3, pend[3]=1.
- Next instr reads rs=3 -> stalls in CHECK; wb_valid addr=3 data=12 -> rf_wr_c pulse, pend[3] clears, then opa=12.
- Instr with rs=0 while RF returns 0xFFFFFFFF -> opa=0; lw (0x23) rt=0 -> dest=0, no pend bit.
- wb_valid addr=9 with pend[9]=0 -> rf_wr_c pulse to 9 with data, wb_err=1 sticky.
- VALID handshake dest=4 on the same edge as wb addr=4 -> pend[4]=1; out_ready held low 5 cycles -> outputs stable, in_ready=0.
